// File: rtl/dizy_keystream_ctrl_if.sv
// Bus bundle between the keystream controller, the DIZY rounds core and the
// keystream consumer.
//   ks_valid/ks_ready/ks_data : keystream word handshake (controller -> consumer)
//   core_load/core_next/core_key : command side of the rounds core
//   core_busy/core_state : status side of the rounds core
// master = controller view, slave = core + consumer view.
interface dizy_keystream_ctrl_if #(
  parameter int SIZE_STATE = 160,
  parameter int SIZE_KEY   = 128,
  parameter int OUT_BITS   = 32
);
  logic                  ks_valid;
  logic                  ks_ready;
  logic [OUT_BITS-1:0]   ks_data;
  logic                  core_load;
  logic                  core_next;
  logic [SIZE_KEY-1:0]   core_key;
  logic                  core_busy;
  logic [SIZE_STATE-1:0] core_state;

  modport master (
    output ks_valid, ks_data, core_load, core_next, core_key,
    input  ks_ready, core_busy, core_state
  );

  modport slave (
    input  ks_valid, ks_data, core_load, core_next, core_key,
    output ks_ready, core_busy, core_state
  );
endinterface

// File: rtl/dizy_keystream_ctrl.sv
// Master sequencer for a DIZY rounds core. Loads the key, optionally absorbs
// an IV, then streams the top OUT_BITS of the core state as keystream words,
// stepping the core with a zero key after every accepted word.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         (re)initialise, level-sampled in IDLE/STREAM/NXT_WAIT
//   iv_en_i         absorb iv_i after key load
//   key_i, iv_i     key and IV, captured on start acceptance
//   init_busy_o     high from start acceptance until the first word is valid
//   ks_cnt_o        accepted words since last init (wraps)
//   bus (master)    keystream handshake and rounds-core command/status
module dizy_keystream_ctrl #(
  parameter int SIZE_STATE = 160,
  parameter int SIZE_KEY   = 128,
  parameter int OUT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  iv_en_i,
  input  logic [SIZE_KEY-1:0]   key_i,
  input  logic [SIZE_KEY-1:0]   iv_i,
  output logic                  init_busy_o,
  output logic [15:0]           ks_cnt_o,
  dizy_keystream_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, KEY_GO, KEY_WAIT, IV_GO, IV_WAIT, STREAM, NXT_GO, NXT_WAIT
  } state_e;

  state_e              state_q;
  logic                first_q;     // first cycle of a WAIT state
  logic                abort_q;     // start seen in NXT_WAIT, reload once core idles
  logic                iv_en_q;
  logic                init_busy_q;
  logic                ks_valid_q;
  logic                core_load_q;
  logic                core_next_q;
  logic [SIZE_KEY-1:0] key_q;
  logic [SIZE_KEY-1:0] iv_q;
  logic [SIZE_KEY-1:0] core_key_q;
  logic [OUT_BITS-1:0] ks_data_q;
  logic [15:0]         ks_cnt_q;

  logic                wait_done;
  logic [OUT_BITS-1:0] top_word;
  logic                unused_state_bits;

  // The core raises busy one cycle after a pulse, so busy is only trusted
  // from the second WAIT cycle on.
  assign wait_done         = !first_q && !bus.core_busy;
  assign top_word          = bus.core_state[SIZE_STATE-1 -: OUT_BITS];
  assign unused_state_bits = ^bus.core_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      abort_q     <= 1'b0;
      iv_en_q     <= 1'b0;
      init_busy_q <= 1'b0;
      ks_valid_q  <= 1'b0;
      core_load_q <= 1'b0;
      core_next_q <= 1'b0;
      key_q       <= '0;
      iv_q        <= '0;
      core_key_q  <= '0;
      ks_data_q   <= '0;
      ks_cnt_q    <= '0;
    end else begin
      core_load_q <= 1'b0;
      core_next_q <= 1'b0;
      case (state_q)
        IDLE, STREAM: begin
          // start beats a coinciding handshake: the word is dropped
          if (start_i) begin
            key_q       <= key_i;
            iv_q        <= iv_i;
            iv_en_q     <= iv_en_i;
            ks_valid_q  <= 1'b0;
            ks_cnt_q    <= '0;
            init_busy_q <= 1'b1;
            core_key_q  <= key_i;
            core_load_q <= 1'b1;
            state_q     <= KEY_GO;
          end else if (state_q == STREAM && ks_valid_q && bus.ks_ready) begin
            ks_valid_q  <= 1'b0;
            ks_cnt_q    <= ks_cnt_q + 16'd1;
            core_key_q  <= '0;
            core_next_q <= 1'b1;
            state_q     <= NXT_GO;
          end
        end
        KEY_GO: begin
          first_q <= 1'b1;
          state_q <= KEY_WAIT;
        end
        KEY_WAIT: begin
          first_q <= 1'b0;
          if (wait_done) begin
            if (iv_en_q) begin
              core_key_q  <= iv_q;
              core_next_q <= 1'b1;
              state_q     <= IV_GO;
            end else begin
              ks_data_q   <= top_word;
              ks_valid_q  <= 1'b1;
              init_busy_q <= 1'b0;
              state_q     <= STREAM;
            end
          end
        end
        IV_GO: begin
          first_q <= 1'b1;
          state_q <= IV_WAIT;
        end
        IV_WAIT: begin
          first_q <= 1'b0;
          if (wait_done) begin
            ks_data_q   <= top_word;
            ks_valid_q  <= 1'b1;
            init_busy_q <= 1'b0;
            state_q     <= STREAM;
          end
        end
        NXT_GO: begin
          first_q <= 1'b1;
          state_q <= NXT_WAIT;
        end
        NXT_WAIT: begin
          first_q <= 1'b0;
          if (start_i && !abort_q) begin
            key_q       <= key_i;
            iv_q        <= iv_i;
            iv_en_q     <= iv_en_i;
            ks_cnt_q    <= '0;
            init_busy_q <= 1'b1;
            abort_q     <= 1'b1;
          end
          if (wait_done) begin
            if (abort_q || start_i) begin
              // deferred reload: the core is idle only now
              core_key_q  <= abort_q ? key_q : key_i;
              core_load_q <= 1'b1;
              abort_q     <= 1'b0;
              state_q     <= KEY_GO;
            end else begin
              ks_data_q  <= top_word;
              ks_valid_q <= 1'b1;
              state_q    <= STREAM;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign init_busy_o   = init_busy_q;
  assign ks_cnt_o      = ks_cnt_q;
  assign bus.ks_valid  = ks_valid_q;
  assign bus.ks_data   = ks_data_q;
  assign bus.core_load = core_load_q;
  assign bus.core_next = core_next_q;
  assign bus.core_key  = core_key_q;
endmodule

// File: tb/tb_dizy_keystream_ctrl.sv
// Bench for dizy_keystream_ctrl. A behavioural rounds core (mixing function
// stand-in for DIZY, busy raised one cycle after each pulse for busy_len
// cycles) sits on the slave side. Expected words are pushed to a queue when a
// start is driven and compared when a handshake occurs.
module tb_dizy_keystream_ctrl;
  localparam int SS = 160;
  localparam int SK = 128;
  localparam int OB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          iv_en = 1'b0;
  logic [SK-1:0] key = '0;
  logic [SK-1:0] iv = '0;
  logic          ks_ready = 1'b0;
  logic          init_busy;
  logic [15:0]   ks_cnt;

  int checks = 0;
  int errors = 0;

  dizy_keystream_ctrl_if #(.SIZE_STATE(SS), .SIZE_KEY(SK), .OUT_BITS(OB)) bus();

  dizy_keystream_ctrl #(.SIZE_STATE(SS), .SIZE_KEY(SK), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .iv_en_i(iv_en), .key_i(key), .iv_i(iv),
    .init_busy_o(init_busy), .ks_cnt_o(ks_cnt), .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [SS-1:0] f_load(input logic [SK-1:0] k);
    return {k, k[127:96] ^ 32'h9e3779b9} ^ 160'h0123456789abcdeffedcba98765432100f1e2d3c;
  endfunction

  function automatic logic [SS-1:0] f_next(input logic [SS-1:0] s, input logic [SK-1:0] k);
    logic [SS-1:0] r;
    r = {s[152:0], s[159:153]} ^ {32'h0, k};
    return (r ^ (r >> 17)) + 160'h5bd1e995;
  endfunction

  // behavioural core
  logic [SS-1:0] cst;
  logic          busy;
  logic          pend;
  int            bcnt;
  int            busy_len = 3;
  assign bus.core_state = cst;
  assign bus.core_busy  = busy;
  assign bus.ks_ready   = ks_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst <= '0; busy <= 1'b0; pend <= 1'b0; bcnt <= 0;
    end else begin
      pend <= bus.core_load || bus.core_next;
      if (bus.core_load)      cst <= f_load(bus.core_key);
      else if (bus.core_next) cst <= f_next(cst, bus.core_key);
      if (pend) begin
        bcnt <= busy_len; busy <= (busy_len > 0);
      end else if (bcnt > 0) begin
        bcnt <= bcnt - 1; busy <= (bcnt > 1);
      end
    end
  end

  // scoreboard
  logic [OB-1:0] sb_q[$];
  logic [SS-1:0] m_st;
  int            exp_cnt = 0;
  int            load_cnt = 0;
  int            next_cnt = 0;
  logic [SK-1:0] last_next_key = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_load || bus.core_next) begin
        checks++;
        if (bus.core_load && bus.core_next) begin
          errors++; $display("FAIL pulse_overlap: load=%0b next=%0b, required never both", bus.core_load, bus.core_next);
        end else if (bus.core_load && bus.core_busy) begin
          errors++; $display("FAIL load_while_busy: core_busy=%0b during load, required 0", bus.core_busy);
        end
        if (bus.core_load) load_cnt++;
        if (bus.core_next) begin next_cnt++; last_next_key = bus.core_key; end
      end
      if (bus.ks_valid && ks_ready && !start) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL sb_empty: got word %h with nothing expected", bus.ks_data);
        end else begin
          logic [OB-1:0] e;
          e = sb_q.pop_front();
          if (bus.ks_data !== e) begin
            errors++; $display("FAIL ks_data: got %h expected %h (word %0d)", bus.ks_data, e, exp_cnt);
          end
        end
        checks++;
        if (ks_cnt !== exp_cnt[15:0]) begin
          errors++; $display("FAIL ks_cnt: got %0d expected %0d", ks_cnt, exp_cnt[15:0]);
        end
        m_st = f_next(m_st, '0);
        sb_q.push_back(m_st[SS-1 -: OB]);
        exp_cnt++;
      end
    end
  end

  task automatic drive_start(input logic [SK-1:0] k, input logic [SK-1:0] v, input logic en);
    @(posedge clk); #1;
    key = k; iv = v; iv_en = en; start = 1'b1;
    m_st = f_load(k);
    if (en) m_st = f_next(m_st, v);
    sb_q.delete();
    sb_q.push_back(m_st[SS-1 -: OB]);
    exp_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.ks_valid) begin ok = 1'b1; return; end
    end
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1; ks_ready = 1'b1;
    @(posedge clk); #1; ks_ready = 1'b0;
  endtask

  localparam logic [SK-1:0] KEY_A = {16'ha000, 112'h0};
  localparam logic [SK-1:0] IV_A  = {16'h5500, 112'h0};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({init_busy, bus.ks_valid, bus.core_load, bus.core_next} !== 4'b0) begin
      errors++; $display("FAIL rst_ctrl: got %b expected 0000", {init_busy, bus.ks_valid, bus.core_load, bus.core_next});
    end
    checks++;
    if ({bus.ks_data, ks_cnt, bus.core_key} !== '0) begin
      errors++; $display("FAIL rst_data: got data=%h cnt=%0d key=%h expected all 0", bus.ks_data, ks_cnt, bus.core_key);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_key_only();
    bit ok; int l0, n0;
    busy_len = 3; l0 = load_cnt; n0 = next_cnt;
    drive_start(KEY_A, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (init_busy !== 1'b1) begin errors++; $display("FAIL t1_init_busy: got %0b expected 1", init_busy); end
    wait_valid(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t1_timeout: ks_valid got 0 expected 1 within 50 cycles"); end
    checks++;
    if (init_busy !== 1'b0) begin errors++; $display("FAIL t1_init_fall: got %0b expected 0", init_busy); end
    checks++;
    if (load_cnt - l0 != 1 || next_cnt - n0 != 0) begin
      errors++; $display("FAIL t1_pulses: got loads=%0d nexts=%0d expected 1/0", load_cnt - l0, next_cnt - n0);
    end
    pulse_ready();
  endtask

  task automatic test_iv();
    bit ok; int l0, n0;
    wait_valid(50, ok);
    l0 = load_cnt; n0 = next_cnt;
    drive_start(KEY_A, IV_A, 1'b1);
    wait_valid(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t2_timeout: ks_valid got 0 expected 1 within 60 cycles"); end
    checks++;
    if (load_cnt - l0 != 1 || next_cnt - n0 != 1) begin
      errors++; $display("FAIL t2_pulses: got loads=%0d nexts=%0d expected 1/1", load_cnt - l0, next_cnt - n0);
    end
    checks++;
    if (last_next_key !== IV_A) begin errors++; $display("FAIL t2_iv_key: got %h expected %h", last_next_key, IV_A); end
  endtask

  task automatic test_backpressure();
    int l0, n0;
    busy_len = 6; l0 = load_cnt; n0 = next_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (!bus.ks_valid || sb_q.size() == 0 || bus.ks_data !== sb_q[0]) begin
        errors++; $display("FAIL t3_hold: got valid=%0b data=%h expected valid=1 data=%h", bus.ks_valid, bus.ks_data, (sb_q.size() != 0) ? sb_q[0] : '0);
      end
    end
    checks++;
    if (load_cnt != l0 || next_cnt != n0) begin
      errors++; $display("FAIL t3_quiet: got loads=%0d nexts=%0d expected 0/0", load_cnt - l0, next_cnt - n0);
    end
    pulse_ready();
    @(negedge clk);
    checks++;
    if (bus.core_next !== 1'b1 || bus.core_key !== '0 || ks_cnt !== 16'd1) begin
      errors++; $display("FAIL t3_next: got next=%0b key=%h cnt=%0d expected 1/0/1", bus.core_next, bus.core_key, ks_cnt);
    end
  endtask

  task automatic test_abort();
    bit ok, seen; int l0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = busy; end
    checks++;
    if (!seen) begin errors++; $display("FAIL t4_busy: core_busy got 0 expected 1 within 10 cycles"); end
    l0 = load_cnt;
    drive_start('0, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      checks++;
      if (bus.core_load !== 1'b0 || init_busy !== 1'b1) begin
        errors++; $display("FAIL t4_wait: got load=%0b init_busy=%0b expected 0/1", bus.core_load, init_busy);
      end
    end
    wait_valid(60, ok);
    checks++;
    if (!ok || load_cnt - l0 != 1 || ks_cnt !== 16'd0) begin
      errors++; $display("FAIL t4_reinit: got valid=%0b loads=%0d cnt=%0d expected 1/1/0", ok, load_cnt - l0, ks_cnt);
    end
    pulse_ready();
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int l0, n0;
    busy_len = 4;
    wait_valid(60, ok);
    n0 = next_cnt;
    drive_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = (next_cnt != n0); end
    checks++;
    if (!seen) begin errors++; $display("FAIL t5_iv_go: core_next got 0 expected 1 within 30 cycles"); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if ({init_busy, bus.ks_valid, bus.core_load, bus.core_next, bus.ks_data, ks_cnt, bus.core_key} !== '0) begin
      errors++; $display("FAIL t5_async: got busy=%0b valid=%0b key=%h expected all 0", init_busy, bus.ks_valid, bus.core_key);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #3; rst_n = 1'b1;
    l0 = load_cnt; n0 = next_cnt;
    repeat (6) @(negedge clk);
    checks++;
    if (load_cnt != l0 || next_cnt != n0 || init_busy !== 1'b0 || bus.ks_valid !== 1'b0) begin
      errors++; $display("FAIL t5_idle: got loads=%0d nexts=%0d busy=%0b valid=%0b expected 0/0/0/0", load_cnt - l0, next_cnt - n0, init_busy, bus.ks_valid);
    end
    test_key_only();
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_valid(60, ok);
    drive_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    ks_ready = 1'b1;
    for (int c = 0; c < 4000 && exp_cnt < 300; c++) begin
      @(posedge clk); #1; busy_len = $urandom_range(0, 3);
    end
    checks++;
    if (exp_cnt < 300) begin errors++; $display("FAIL t6_stream: got %0d words expected 300 within 4000 cycles", exp_cnt); end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1; ks_ready = $urandom_range(0, 1); busy_len = $urandom_range(0, 2);
    end
    ks_ready = 1'b0;
    checks++;
    if (exp_cnt < 320) begin errors++; $display("FAIL t6_random_ready: got %0d words expected at least 320", exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_key_only();
    test_iv();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
